// File: rtl/wr_demux_2_32_pkg.sv
// Shared definitions for the store-side two-slave steering unit:
// state encoding and the system memory-map windows.
package wr_demux_2_32_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2,
    ST_ERR   = 2'd3
  } wr_state_e;

  localparam logic [31:0] DEF_BASE0 = 32'h0000_7F00;
  localparam logic [31:0] DEF_SIZE0 = 32'h0000_0010;
  localparam logic [31:0] DEF_BASE1 = 32'h0000_7F10;
  localparam logic [31:0] DEF_SIZE1 = 32'h0000_0010;

endpackage

// File: rtl/wr_window_decode.sv
// Combinational address compare against two windows; also used by the
// read-side select. Offset follows window 0 when both (or neither) hit.
module wr_window_decode #(
  parameter logic [31:0] BASE0 = 32'h0000_7F00,
  parameter logic [31:0] SIZE0 = 32'h0000_0010,
  parameter logic [31:0] BASE1 = 32'h0000_7F10,
  parameter logic [31:0] SIZE1 = 32'h0000_0010
) (
  input  logic [31:0] addr,
  output logic        hit0,
  output logic        hit1,
  output logic [31:0] offset
);

  logic [31:0] off0, off1;

  // Compare via the offset so BASE+SIZE at the top of the map cannot overflow.
  assign off0   = addr - BASE0;
  assign off1   = addr - BASE1;
  assign hit0   = (addr >= BASE0) && (off0 < SIZE0);
  assign hit1   = (addr >= BASE1) && (off1 < SIZE1);
  assign offset = (!hit0 && hit1) ? off1 : off0;

endmodule

// File: rtl/wr_demux_2_32.sv
// Store steering: one-entry holding register forwarding a CPU store to
// device 0, device 1, or absorbing it as an unmapped-address error.
module wr_demux_2_32
  import wr_demux_2_32_pkg::*;
#(
  parameter logic [31:0] BASE0 = DEF_BASE0,
  parameter logic [31:0] SIZE0 = DEF_SIZE0,
  parameter logic [31:0] BASE1 = DEF_BASE1,
  parameter logic [31:0] SIZE1 = DEF_SIZE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        dev0_valid,
  input  logic        dev0_ready,
  output logic        dev1_valid,
  input  logic        dev1_ready,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_be,
  output logic        err_pulse,
  output logic [31:0] err_addr
);

  wr_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        hit0, hit1;
  logic [31:0] offset;
  logic        release_hold, accept;

  wr_window_decode #(
    .BASE0(BASE0), .SIZE0(SIZE0), .BASE1(BASE1), .SIZE1(SIZE1)
  ) u_decode (
    .addr   (req_addr),
    .hit0   (hit0),
    .hit1   (hit1),
    .offset (offset)
  );

  // Ready only looks at registered state and the selected device's ready,
  // so a draining slot can be refilled in the same cycle.
  always_comb begin
    release_hold = ((state_q == ST_HOLD0) && dev0_ready) ||
                   ((state_q == ST_HOLD1) && dev1_ready);
    req_ready    = (state_q == ST_EMPTY) || (state_q == ST_ERR) || release_hold;
    accept       = req_valid && req_ready;

    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_addr_d = err_addr_q;

    if (accept) begin
      addr_d  = offset;
      wdata_d = req_wdata;
      be_d    = req_be;
      if (hit0)      state_d = ST_HOLD0;
      else if (hit1) state_d = ST_HOLD1;
      else begin
        state_d    = ST_ERR;
        err_addr_d = req_addr;
      end
    end else if (release_hold || (state_q == ST_ERR)) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign dev0_valid = (state_q == ST_HOLD0);
  assign dev1_valid = (state_q == ST_HOLD1);
  assign err_pulse  = (state_q == ST_ERR);
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_be     = be_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_wr_demux_2_32.sv
// Directed bench for wr_demux_2_32: routing, stalls, back-to-back, errors,
// window boundaries and reset during a pending store.
module tb_wr_demux_2_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        dev0_valid, dev0_ready, dev1_valid, dev1_ready;
  logic [31:0] dev_addr, dev_wdata;
  logic [3:0]  dev_be;
  logic        err_pulse;
  logic [31:0] err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wr_demux_2_32 dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .dev0_valid(dev0_valid), .dev0_ready(dev0_ready),
    .dev1_valid(dev1_valid), .dev1_ready(dev1_ready),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
    .err_pulse(err_pulse), .err_addr(err_addr)
  );

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    dev0_ready = 1'b0; dev1_ready = 1'b0;
    step(); step();
    reset = 1'b0; #1;
    n_cmp++; if (dev0_valid !== 1'b0 || dev1_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b%b want 00", dev0_valid, dev1_valid); end
    n_cmp++; if (dev_addr !== 32'h0 || dev_wdata !== 32'h0 || dev_be !== 4'h0) begin n_bad++; $display("FAIL rst_payload: got %h %h %h want 0", dev_addr, dev_wdata, dev_be); end
    n_cmp++; if (err_pulse !== 1'b0 || err_addr !== 32'h0) begin n_bad++; $display("FAIL rst_err: got %b %h want 0 0", err_pulse, err_addr); end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_dev0();
    dev0_ready = 1'b1; dev1_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h7F04; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
    #1;
    n_cmp++; if (dev0_valid !== 1'b0) begin n_bad++; $display("FAIL d0_comb: got %b want 0", dev0_valid); end
    step(); req_valid = 1'b0; #1;
    n_cmp++; if (dev0_valid !== 1'b1 || dev1_valid !== 1'b0) begin n_bad++; $display("FAIL d0_valid: got %b%b want 10", dev0_valid, dev1_valid); end
    n_cmp++; if (dev_addr !== 32'h4 || dev_wdata !== 32'hDEAD_BEEF || dev_be !== 4'hF) begin n_bad++; $display("FAIL d0_payload: got %h %h %h want 4 deadbeef f", dev_addr, dev_wdata, dev_be); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL d0_ready: got %b want 1", req_ready); end
    step();
    n_cmp++; if (dev0_valid !== 1'b0 || dev1_valid !== 1'b0) begin n_bad++; $display("FAIL d0_drop: got %b%b want 00", dev0_valid, dev1_valid); end
  endtask

  task automatic test_stall_dev1();
    dev0_ready = 1'b1; dev1_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h7F18; req_wdata = 32'h1234_5678; req_be = 4'h3;
    step(); req_valid = 1'b0; req_addr = 32'h7F00; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dev1_ready = 1'b1;
      #1;
      n_cmp++; if (dev1_valid !== 1'b1 || dev0_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b%b want 01", i, dev0_valid, dev1_valid); end
      n_cmp++; if (dev_addr !== 32'h8 || dev_wdata !== 32'h1234_5678 || dev_be !== 4'h3) begin n_bad++; $display("FAIL stall_payload[%0d]: got %h %h %h want 8 12345678 3", i, dev_addr, dev_wdata, dev_be); end
      n_cmp++; if (req_ready !== (i == 3)) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want %b", i, req_ready, (i == 3)); end
      step();
    end
    n_cmp++; if (dev1_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", dev1_valid); end
  endtask

  task automatic test_ignore_other_ready();
    dev0_ready = 1'b0; dev1_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h7F0C; req_wdata = 32'hA5A5_0001; req_be = 4'h1;
    step(); req_valid = 1'b0; #1;
    n_cmp++; if (dev0_valid !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL ign_hold: got valid %b ready %b want 1 0", dev0_valid, req_ready); end
    step();
    n_cmp++; if (dev0_valid !== 1'b1 || dev_addr !== 32'hC) begin n_bad++; $display("FAIL ign_stay: got %b %h want 1 c", dev0_valid, dev_addr); end
    dev0_ready = 1'b1; step();
    n_cmp++; if (dev0_valid !== 1'b0) begin n_bad++; $display("FAIL ign_release: got %b want 0", dev0_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] offs  [3];
    logic [1:0]  vexp  [3];
    addrs = '{32'h7F00, 32'h7F14, 32'h7F08};
    offs  = '{32'h0, 32'h4, 32'h8};
    vexp  = '{2'b10, 2'b01, 2'b10};
    dev0_ready = 1'b1; dev1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = addrs[i]; req_wdata = 32'hC0DE_0000 + i; req_be = 4'hF; #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
      step();
      n_cmp++; if ({dev0_valid, dev1_valid} !== vexp[i] || dev_addr !== offs[i] || dev_wdata !== 32'hC0DE_0000 + i) begin
        n_bad++; $display("FAIL b2b_out[%0d]: got %b%b %h %h want %b %h %h", i, dev0_valid, dev1_valid, dev_addr, dev_wdata, vexp[i], offs[i], 32'hC0DE_0000 + i);
      end
    end
    req_valid = 1'b0; step();
    n_cmp++; if (dev0_valid !== 1'b0 || dev1_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b%b want 00", dev0_valid, dev1_valid); end
  endtask

  task automatic test_err();
    dev0_ready = 1'b1; dev1_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_1000; req_wdata = 32'h5555_AAAA; req_be = 4'hF;
    step(); req_valid = 1'b0; #1;
    n_cmp++; if (err_pulse !== 1'b1 || err_addr !== 32'h1000) begin n_bad++; $display("FAIL err_pulse: got %b %h want 1 1000", err_pulse, err_addr); end
    n_cmp++; if (dev0_valid !== 1'b0 || dev1_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL err_side: got %b%b ready %b want 00 1", dev0_valid, dev1_valid, req_ready); end
    step();
    n_cmp++; if (err_pulse !== 1'b0 || err_addr !== 32'h1000) begin n_bad++; $display("FAIL err_sticky: got %b %h want 0 1000", err_pulse, err_addr); end
  endtask

  task automatic test_bounds();
    dev0_ready = 1'b1; dev1_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h7F10; req_wdata = 32'h0000_0011; req_be = 4'h0;
    step();
    n_cmp++; if (dev1_valid !== 1'b1 || dev_addr !== 32'h0 || dev_be !== 4'h0) begin n_bad++; $display("FAIL bnd_lo1: got %b %h %h want 1 0 0", dev1_valid, dev_addr, dev_be); end
    req_addr = 32'h7F0F; req_wdata = 32'h0000_0022; req_be = 4'h8;
    step();
    n_cmp++; if (dev0_valid !== 1'b1 || dev_addr !== 32'hF || dev_be !== 4'h8) begin n_bad++; $display("FAIL bnd_hi0: got %b %h %h want 1 f 8", dev0_valid, dev_addr, dev_be); end
    req_addr = 32'h7F20;
    step();
    n_cmp++; if (err_pulse !== 1'b1 || err_addr !== 32'h7F20) begin n_bad++; $display("FAIL bnd_past1: got %b %h want 1 7f20", err_pulse, err_addr); end
    req_addr = 32'h7EFF;
    step(); req_valid = 1'b0;
    n_cmp++; if (err_pulse !== 1'b1 || err_addr !== 32'h7EFF || dev0_valid !== 1'b0) begin n_bad++; $display("FAIL bnd_below0: got %b %h %b want 1 7eff 0", err_pulse, err_addr, dev0_valid); end
    step();
  endtask

  task automatic test_reset_mid_hold();
    dev0_ready = 1'b0; dev1_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h7F1C; req_wdata = 32'hFEED_FACE; req_be = 4'hF;
    step(); req_valid = 1'b0; #1;
    n_cmp++; if (dev1_valid !== 1'b1) begin n_bad++; $display("FAIL rmh_hold: got %b want 1", dev1_valid); end
    reset = 1'b1; step(); reset = 1'b0; #1;
    n_cmp++; if (dev1_valid !== 1'b0 || dev0_valid !== 1'b0 || err_pulse !== 1'b0) begin n_bad++; $display("FAIL rmh_valid: got %b%b err %b want 00 0", dev0_valid, dev1_valid, err_pulse); end
    n_cmp++; if (dev_addr !== 32'h0 || dev_wdata !== 32'h0 || dev_be !== 4'h0 || err_addr !== 32'h0) begin n_bad++; $display("FAIL rmh_regs: got %h %h %h %h want 0", dev_addr, dev_wdata, dev_be, err_addr); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rmh_ready: got %b want 1", req_ready); end
  endtask

  // err_pulse and a device valid must never coincide.
  always @(negedge clk) begin
    if (!reset && err_pulse && (dev0_valid || dev1_valid)) begin
      n_bad++; $display("FAIL excl: err_pulse with valid %b%b", dev0_valid, dev1_valid);
    end
  end

  initial begin
    test_reset();
    test_dev0();
    test_stall_dev1();
    test_ignore_other_ready();
    test_back_to_back();
    test_err();
    test_bounds();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
